// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, a direct-mapped one-word-per-line instruction
// cache, and a single-outstanding word-read port to the memory controller.
module if_fetch #(
    parameter int          ICACHE_IDX_W = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_flag_in,
    input  logic [31:0] branch_target_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_ready_in,
    input  logic [31:0] mem_data_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid_out
);

    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic [0:0] {
        LOOKUP   = 1'b0,
        WAIT_MEM = 1'b1
    } fetch_state_t;

    fetch_state_t state, state_nxt;

    logic [31:0] pc, pc_nxt;
    logic [31:0] miss_addr, miss_addr_nxt;
    logic        discard, discard_nxt;

    logic [31:0] pc_out_nxt;
    logic [31:0] inst_out_nxt;
    logic        inst_valid_nxt;
    logic        mem_req_nxt;
    logic [31:0] mem_addr_nxt;

    logic [LINES-1:0] line_valid;
    logic [TAG_W-1:0] line_tag  [LINES];
    logic [31:0]      line_data [LINES];

    logic [ICACHE_IDX_W-1:0] pc_idx, fill_idx;
    logic [TAG_W-1:0]        pc_tag, fill_tag;
    logic                    hit;
    logic                    fill_en;
    logic [31:0]             target;

    assign pc_idx   = pc[ICACHE_IDX_W+1:2];
    assign pc_tag   = pc[31:ICACHE_IDX_W+2];
    assign fill_idx = miss_addr[ICACHE_IDX_W+1:2];
    assign fill_tag = miss_addr[31:ICACHE_IDX_W+2];
    assign hit      = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
    assign target   = branch_target_in & ~32'h3;

    // Memory handshake: mem_req_out rises on the edge that enters WAIT_MEM and
    // stays high with mem_addr_out frozen until the edge that samples mem_ready_in=1;
    // that same edge drops the request, so only one read is ever in flight.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        miss_addr_nxt  = miss_addr;
        discard_nxt    = discard;
        pc_out_nxt     = pc_out;
        inst_out_nxt   = inst_out;
        inst_valid_nxt = inst_valid_out;
        mem_req_nxt    = mem_req_out;
        mem_addr_nxt   = mem_addr_out;
        fill_en        = 1'b0;

        case (state)
            LOOKUP: begin
                if (branch_flag_in) begin
                    pc_nxt         = target;
                    inst_valid_nxt = 1'b0;
                end else if (!stall_in) begin
                    if (hit) begin
                        pc_out_nxt     = pc;
                        inst_out_nxt   = line_data[pc_idx];
                        inst_valid_nxt = 1'b1;
                        pc_nxt         = pc + 32'd4;
                    end else begin
                        miss_addr_nxt  = pc;
                        mem_req_nxt    = 1'b1;
                        mem_addr_nxt   = pc;
                        inst_valid_nxt = 1'b0;
                        state_nxt      = WAIT_MEM;
                    end
                end
            end

            WAIT_MEM: begin
                if (mem_ready_in) begin
                    // The line is filled even when the word itself is thrown away.
                    fill_en     = 1'b1;
                    mem_req_nxt = 1'b0;
                    state_nxt   = LOOKUP;
                    if (branch_flag_in) begin
                        pc_nxt         = target;
                        inst_valid_nxt = 1'b0;
                        discard_nxt    = 1'b0;
                    end else if (discard) begin
                        discard_nxt = 1'b0;
                        if (!stall_in) begin
                            inst_valid_nxt = 1'b0;
                        end
                    end else if (!stall_in) begin
                        pc_out_nxt     = miss_addr;
                        inst_out_nxt   = mem_data_in;
                        inst_valid_nxt = 1'b1;
                        pc_nxt         = miss_addr + 32'd4;
                    end
                end else if (branch_flag_in) begin
                    pc_nxt         = target;
                    inst_valid_nxt = 1'b0;
                    discard_nxt    = 1'b1;
                end else if (!stall_in) begin
                    inst_valid_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = LOOKUP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= LOOKUP;
            pc             <= RESET_PC;
            miss_addr      <= 32'h0;
            discard        <= 1'b0;
            pc_out         <= 32'h0;
            inst_out       <= 32'h0;
            inst_valid_out <= 1'b0;
            mem_req_out    <= 1'b0;
            mem_addr_out   <= 32'h0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            miss_addr      <= miss_addr_nxt;
            discard        <= discard_nxt;
            pc_out         <= pc_out_nxt;
            inst_out       <= inst_out_nxt;
            inst_valid_out <= inst_valid_nxt;
            mem_req_out    <= mem_req_nxt;
            mem_addr_out   <= mem_addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid <= '0;
        end else if (fill_en) begin
            line_valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= mem_data_in;
        end
    end

endmodule
